// File: rtl/pwm_duty_sequencer_pkg.sv
// ============================================================================
// Module      : pwm_duty_sequencer_pkg
// Description : Shared state encodings and default widths for the PWM duty
//               sequencer, its step timer and neighbouring PWM blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_duty_sequencer_pkg;

    localparam int DEF_DUTY_W       = 4;
    localparam int DEF_DUTY_MAX     = 10;
    localparam int DEF_INIT_TARGET  = 5;
    localparam int DEF_STEP_PERIODS = 4;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_duty_sequencer_if.sv
// ============================================================================
// Module      : pwm_duty_sequencer_if
// Description : Control/handshake bundle between host, debouncers, PWM counter
//               and the duty sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_duty_sequencer_if #(
    parameter int DUTY_W = 4
);

    logic              enable;
    logic              period_end;
    logic              inc_pulse;
    logic              dec_pulse;
    logic              tgt_valid;
    logic [DUTY_W-1:0] tgt_duty;
    logic              tgt_ready;
    logic [DUTY_W-1:0] duty_out;
    logic              busy;
    logic              at_target;

    modport master (
        output enable,
        output period_end,
        output inc_pulse,
        output dec_pulse,
        output tgt_valid,
        output tgt_duty,
        input  tgt_ready,
        input  duty_out,
        input  busy,
        input  at_target
    );

    modport slave (
        input  enable,
        input  period_end,
        input  inc_pulse,
        input  dec_pulse,
        input  tgt_valid,
        input  tgt_duty,
        output tgt_ready,
        output duty_out,
        output busy,
        output at_target
    );

endinterface

`default_nettype wire

// File: rtl/pwm_duty_sequencer_step_timer.sv
// ============================================================================
// Module      : pwm_step_timer
// Description : Counts PWM period_end pulses and strobes once every
//               STEP_PERIODS pulses; clear_i holds the count at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_step_timer
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int STEP_PERIODS = DEF_STEP_PERIODS
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic tick_i,
    output logic step_o
);

    localparam int               CNT_W = cnt_width(STEP_PERIODS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_PERIODS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        step_o  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                step_o  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
// ============================================================================
// Module      : pwm_duty_sequencer
// Description : Owns the PWM duty value; ramps it toward a button/host target
//               one count per STEP_PERIODS periods, only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_sequencer
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int DUTY_MAX     = DEF_DUTY_MAX,
    parameter int INIT_TARGET  = DEF_INIT_TARGET,
    parameter int STEP_PERIODS = DEF_STEP_PERIODS
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_duty_sequencer_if.slave  seq_if
);

    localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(INIT_TARGET);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [DUTY_W-1:0] target_q;
    logic [DUTY_W-1:0] target_d;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;

    logic [DUTY_W-1:0] w_goal;
    logic              w_ready;
    logic              w_host_xfer;
    logic              w_step;

    assign w_goal      = seq_if.enable ? target_q : '0;
    assign w_ready     = (state_q != ST_RAMP);
    assign w_host_xfer = seq_if.tgt_valid & w_ready;

    // Timer only runs while ramping, so every RAMP entry starts from zero.
    pwm_step_timer #(
        .STEP_PERIODS (STEP_PERIODS)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q != ST_RAMP),
        .tick_i  (seq_if.period_end),
        .step_o  (w_step)
    );

    always_comb begin
        target_d = target_q;
        if (w_host_xfer) begin
            target_d = (seq_if.tgt_duty > MAX_D) ? MAX_D : seq_if.tgt_duty;
        end else if (seq_if.inc_pulse && !seq_if.dec_pulse) begin
            if (target_q < MAX_D) begin
                target_d = target_q + 1'b1;
            end
        end else if (seq_if.dec_pulse && !seq_if.inc_pulse) begin
            if (target_q != '0) begin
                target_d = target_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_OFF: begin
                duty_d = '0;
                if (seq_if.enable) begin
                    state_d = (w_goal != '0) ? ST_RAMP : ST_HOLD;
                end
            end
            ST_RAMP: begin
                if (w_step) begin
                    // Direction is re-evaluated every step so a moved goal reverses cleanly.
                    if (w_goal > duty_q) begin
                        duty_d = duty_q + 1'b1;
                    end else if (w_goal < duty_q) begin
                        duty_d = duty_q - 1'b1;
                    end
                    if (duty_d == w_goal) begin
                        state_d = seq_if.enable ? ST_HOLD : ST_OFF;
                    end
                end
            end
            ST_HOLD: begin
                if (w_goal != duty_q) begin
                    state_d = ST_RAMP;
                end else if (!seq_if.enable && (duty_q == '0)) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            target_q <= INIT_D;
            duty_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            duty_q   <= duty_d;
        end
    end

    assign seq_if.tgt_ready = w_ready;
    assign seq_if.duty_out  = duty_q;
    assign seq_if.busy      = (state_q == ST_RAMP);
    assign seq_if.at_target = (state_q == ST_HOLD) & seq_if.enable;

endmodule

`default_nettype wire
